// File: rtl/spell_mem_ctrl.sv
// spell_mem_ctrl: bridges a CPU request port onto a shared target bus, steering 0x20-0x3F to IO, all else to RAM.
// Define SPELL_MEM_TIMEOUT_EN to build a 16-cycle wait timeout with a sticky bus_err flag.
module spell_mem_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_req,
  input  logic       cpu_write,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_ack,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_write,
  output logic       io_select,
  output logic       ram_select,
  input  logic [7:0] io_rdata,
  input  logic [7:0] ram_rdata,
  input  logic       io_ready,
  input  logic       ram_ready,
  output logic       bus_err
);

  typedef enum logic [1:0] {IDLE, IO_WAIT, RAM_WAIT, DONE} state_t;

  state_t     state_reg, state_next;
  logic [7:0] addr_next, wdata_next, rdata_next;
  logic       write_next, io_sel_next, ram_sel_next, ack_next;
  logic       waiting, sel_ready, timeout;
  logic [7:0] sel_rdata;

  assign waiting = (state_reg == IO_WAIT) || (state_reg == RAM_WAIT);

  // Only the target we are waiting on is listened to; ready is meaningless elsewhere.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = 8'h00;
    if (state_reg == IO_WAIT) begin
      sel_ready = io_ready;
      sel_rdata = io_rdata;
    end else if (state_reg == RAM_WAIT) begin
      sel_ready = ram_ready;
      sel_rdata = ram_rdata;
    end
  end

`ifdef SPELL_MEM_TIMEOUT_EN
  logic [3:0] tmo_cnt_reg;
  logic       bus_err_reg;

  // Counter value 15 means this is the 16th wait cycle without ready.
  assign timeout = waiting && !sel_ready && (tmo_cnt_reg == 4'hF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_reg <= 4'h0;
      bus_err_reg <= 1'b0;
    end else begin
      if (!waiting)
        tmo_cnt_reg <= 4'h0;
      else if (!sel_ready)
        tmo_cnt_reg <= tmo_cnt_reg + 4'd1;
      if (timeout)
        bus_err_reg <= 1'b1;
    end
  end

  assign bus_err = bus_err_reg;
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    addr_next    = mem_addr;
    wdata_next   = mem_wdata;
    write_next   = mem_write;
    io_sel_next  = io_select;
    ram_sel_next = ram_select;
    ack_next     = 1'b0;
    rdata_next   = cpu_rdata;
    case (state_reg)
      IDLE: begin
        if (cpu_req) begin
          addr_next  = cpu_addr;
          wdata_next = cpu_wdata;
          write_next = cpu_write;
          if ((cpu_addr >= 8'h20) && (cpu_addr <= 8'h3F)) begin
            io_sel_next = 1'b1;
            state_next  = IO_WAIT;
          end else begin
            ram_sel_next = 1'b1;
            state_next   = RAM_WAIT;
          end
        end
      end
      IO_WAIT, RAM_WAIT: begin
        if (sel_ready || timeout) begin
          io_sel_next  = 1'b0;
          ram_sel_next = 1'b0;
          ack_next     = 1'b1;
          state_next   = DONE;
          if (!sel_ready)
            rdata_next = 8'hFF;
          else if (mem_write)
            rdata_next = 8'h00;
          else
            rdata_next = sel_rdata;
        end
      end
      DONE: begin
        // One cycle with both selects low separates consecutive accesses.
        io_sel_next  = 1'b0;
        ram_sel_next = 1'b0;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      mem_addr   <= 8'h00;
      mem_wdata  <= 8'h00;
      mem_write  <= 1'b0;
      io_select  <= 1'b0;
      ram_select <= 1'b0;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= 8'h00;
    end else begin
      state_reg  <= state_next;
      mem_addr   <= addr_next;
      mem_wdata  <= wdata_next;
      mem_write  <= write_next;
      io_select  <= io_sel_next;
      ram_select <= ram_sel_next;
      cpu_ack    <= ack_next;
      cpu_rdata  <= rdata_next;
    end
  end

endmodule
